// File: rtl/ecpa_pkg.sv
// rtl/ecpa_pkg.sv - shared types, register map and helpers for the Jacobian point-add sequencer
package ecpa_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } op_t;

    typedef logic [3:0] reg_idx_t;

    typedef struct packed {
        op_t      op;
        reg_idx_t dst;
        reg_idx_t srcA;
        reg_idx_t srcB;
    } uop_t;

    localparam int ECPA_NUM_OPS = 23;
    localparam logic [4:0] ECPA_LAST_PC = 5'(ECPA_NUM_OPS - 1);

    // Physical registers; intermediates reuse slots whose previous value is dead.
    localparam reg_idx_t R_X1   = 4'd0;
    localparam reg_idx_t R_Y1   = 4'd1;
    localparam reg_idx_t R_Z1   = 4'd2;
    localparam reg_idx_t R_X2   = 4'd3;
    localparam reg_idx_t R_Y2   = 4'd4;
    localparam reg_idx_t R_Z2   = 4'd5;
    localparam reg_idx_t R_Z1Z2 = 4'd6;
    localparam reg_idx_t R_Z1SQ = 4'd7;
    localparam reg_idx_t R_Z2SQ = 4'd8;
    localparam reg_idx_t R_Z1CU = 4'd9;
    localparam reg_idx_t R_Z2CU = 4'd10;
    localparam reg_idx_t R_X3   = 4'd11;
    localparam reg_idx_t R_Y3   = 4'd12;

    localparam reg_idx_t R_U1 = R_X1;
    localparam reg_idx_t R_V  = R_X1;
    localparam reg_idx_t R_W  = R_X1;
    localparam reg_idx_t R_RW = R_X1;
    localparam reg_idx_t R_S1 = R_Y1;
    localparam reg_idx_t R_SH = R_Y1;
    localparam reg_idx_t R_U2 = R_X2;
    localparam reg_idx_t R_H  = R_X2;
    localparam reg_idx_t R_S2 = R_Y2;
    localparam reg_idx_t R_R  = R_Y2;
    localparam reg_idx_t R_Z3 = R_Z1Z2;
    localparam reg_idx_t R_H2 = R_Z1SQ;
    localparam reg_idx_t R_H3 = R_Z2SQ;
    localparam reg_idx_t R_R2 = R_Z1CU;
    localparam reg_idx_t R_T  = R_Z1CU;
    localparam reg_idx_t R_2V = R_Z2CU;

    function automatic uop_t mk_uop(op_t op, reg_idx_t dst, reg_idx_t a, reg_idx_t b);
        uop_t u;
        u.op   = op;
        u.dst  = dst;
        u.srcA = a;
        u.srcB = b;
        return u;
    endfunction

endpackage

// File: rtl/ecpa_ucode_rom.sv
// rtl/ecpa_ucode_rom.sv - combinational 23-entry micro-op program for Jacobian point addition
module ecpa_ucode_rom
    import ecpa_pkg::*;
(
    input  logic [4:0] pc_i,
    output uop_t       uop_o
);

    always_comb begin
        uop_o = '0;
        case (pc_i)
            5'd0:  uop_o = mk_uop(OP_MUL, R_Z1Z2, R_Z1,   R_Z2);
            5'd1:  uop_o = mk_uop(OP_MUL, R_Z1SQ, R_Z1,   R_Z1);
            5'd2:  uop_o = mk_uop(OP_MUL, R_Z2SQ, R_Z2,   R_Z2);
            5'd3:  uop_o = mk_uop(OP_MUL, R_Z1CU, R_Z1SQ, R_Z1);
            5'd4:  uop_o = mk_uop(OP_MUL, R_Z2CU, R_Z2SQ, R_Z2);
            5'd5:  uop_o = mk_uop(OP_MUL, R_U1,   R_X1,   R_Z2SQ);
            5'd6:  uop_o = mk_uop(OP_MUL, R_U2,   R_X2,   R_Z1SQ);
            5'd7:  uop_o = mk_uop(OP_MUL, R_S1,   R_Y1,   R_Z2CU);
            5'd8:  uop_o = mk_uop(OP_MUL, R_S2,   R_Y2,   R_Z1CU);
            5'd9:  uop_o = mk_uop(OP_SUB, R_H,    R_U2,   R_U1);
            5'd10: uop_o = mk_uop(OP_SUB, R_R,    R_S2,   R_S1);
            5'd11: uop_o = mk_uop(OP_MUL, R_Z3,   R_Z1Z2, R_H);
            5'd12: uop_o = mk_uop(OP_MUL, R_H2,   R_H,    R_H);
            5'd13: uop_o = mk_uop(OP_MUL, R_H3,   R_H2,   R_H);
            5'd14: uop_o = mk_uop(OP_MUL, R_V,    R_U1,   R_H2);
            5'd15: uop_o = mk_uop(OP_MUL, R_R2,   R_R,    R_R);
            5'd16: uop_o = mk_uop(OP_ADD, R_2V,   R_V,    R_V);
            5'd17: uop_o = mk_uop(OP_SUB, R_T,    R_R2,   R_H3);
            5'd18: uop_o = mk_uop(OP_SUB, R_X3,   R_T,    R_2V);
            5'd19: uop_o = mk_uop(OP_SUB, R_W,    R_V,    R_X3);
            5'd20: uop_o = mk_uop(OP_MUL, R_RW,   R_R,    R_W);
            5'd21: uop_o = mk_uop(OP_MUL, R_SH,   R_S1,   R_H3);
            5'd22: uop_o = mk_uop(OP_SUB, R_Y3,   R_RW,   R_SH);
            default: uop_o = '0;
        endcase
    end

endmodule

// File: rtl/ecpa_seq_ctrl.sv
// rtl/ecpa_seq_ctrl.sv - point-add sequencer over one shared mod-mul and one mod-add/sub unit; optional ECPA_INF_BYPASS_EN
module ecpa_seq_ctrl
    import ecpa_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [255:0] p,
    input  logic [255:0] X1,
    input  logic [255:0] Y1,
    input  logic [255:0] Z1,
    input  logic [255:0] X2,
    input  logic [255:0] Y2,
    input  logic [255:0] Z2,
    output logic [255:0] X3,
    output logic [255:0] Y3,
    output logic [255:0] Z3,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_mul_start,
    output logic [255:0] o_mul_a,
    output logic [255:0] o_mul_b,
    input  logic [255:0] i_mul_p,
    input  logic         i_mul_ready,
    output logic         o_as_start,
    output logic         o_as_sub,
    output logic [255:0] o_as_a,
    output logic [255:0] o_as_b,
    input  logic [255:0] i_as_result,
    input  logic         i_as_done,
    output logic [255:0] o_m
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t       state_q;
    logic [4:0]   pc_q;
    logic [255:0] rf_q [16];
    logic [255:0] p_q;
    logic [255:0] x3_q, y3_q, z3_q;
    logic         busy_q, done_q;

    uop_t         cur_uop;
    logic         is_mul, active, unit_ready;
    logic [255:0] unit_res, opnd_a, opnd_b;

    ecpa_ucode_rom u_rom (
        .pc_i  (pc_q),
        .uop_o (cur_uop)
    );

    // Operands come straight from the register file; nothing writes it while an op is outstanding.
    assign is_mul     = (cur_uop.op == OP_MUL);
    assign active     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign opnd_a     = rf_q[cur_uop.srcA];
    assign opnd_b     = rf_q[cur_uop.srcB];
    assign unit_ready = is_mul ? i_mul_ready : i_as_done;
    assign unit_res   = is_mul ? i_mul_p : i_as_result;

    assign o_mul_start = (state_q == ST_ISSUE) && is_mul;
    assign o_as_start  = (state_q == ST_ISSUE) && !is_mul;
    assign o_as_sub    = active && (cur_uop.op == OP_SUB);
    assign o_mul_a     = (active && is_mul)  ? opnd_a : '0;
    assign o_mul_b     = (active && is_mul)  ? opnd_b : '0;
    assign o_as_a      = (active && !is_mul) ? opnd_a : '0;
    assign o_as_b      = (active && !is_mul) ? opnd_b : '0;

    assign o_m    = p_q;
    assign X3     = x3_q;
    assign Y3     = y3_q;
    assign Z3     = z3_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            p_q     <= '0;
            x3_q    <= '0;
            y3_q    <= '0;
            z3_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        p_q        <= p;
                        rf_q[R_X1] <= X1;
                        rf_q[R_Y1] <= Y1;
                        rf_q[R_Z1] <= Z1;
                        rf_q[R_X2] <= X2;
                        rf_q[R_Y2] <= Y2;
                        rf_q[R_Z2] <= Z2;
                        pc_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
`ifdef ECPA_INF_BYPASS_EN
                        // A point at infinity makes the sum the other operand.
                        if (Z1 == '0 || Z2 == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            x3_q    <= (Z1 == '0) ? X2 : X1;
                            y3_q    <= (Z1 == '0) ? Y2 : Y1;
                            z3_q    <= (Z1 == '0) ? Z2 : Z1;
                        end
`endif
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (unit_ready) begin
                        rf_q[cur_uop.dst] <= unit_res;
                        if (pc_q == ECPA_LAST_PC) begin
                            // The final op produces Y3, so it is taken from the result bus directly.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            pc_q    <= '0;
                            x3_q    <= rf_q[R_X3];
                            y3_q    <= unit_res;
                            z3_q    <= rf_q[R_Z3];
                        end else begin
                            pc_q    <= pc_q + 5'd1;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecpa_seq_ctrl.sv
// tb/tb_ecpa_seq_ctrl.sv - self-checking bench for ecpa_seq_ctrl with behavioural mod-mul and mod-add/sub units
module tb_ecpa_seq_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [255:0] p = '0, X1 = '0, Y1 = '0, Z1 = '0, X2 = '0, Y2 = '0, Z2 = '0;
    logic [255:0] X3, Y3, Z3, o_mul_a, o_mul_b, o_as_a, o_as_b, o_m;
    logic         o_busy, o_done, o_mul_start, o_as_start, o_as_sub;
    logic [255:0] i_mul_p = '0, i_as_result = '0;
    logic         i_mul_ready = 1'b0, i_as_done = 1'b0;

    ecpa_seq_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .p(p),
        .X1(X1), .Y1(Y1), .Z1(Z1), .X2(X2), .Y2(Y2), .Z2(Z2),
        .X3(X3), .Y3(Y3), .Z3(Z3), .o_busy(o_busy), .o_done(o_done),
        .o_mul_start(o_mul_start), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
        .i_mul_p(i_mul_p), .i_mul_ready(i_mul_ready),
        .o_as_start(o_as_start), .o_as_sub(o_as_sub), .o_as_a(o_as_a), .o_as_b(o_as_b),
        .i_as_result(i_as_result), .i_as_done(i_as_done), .o_m(o_m)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] p, x1, y1, z1, x2, y2, z2;
        int           k;
        logic [255:0] ex, ey, ez;
        int           lat, nmul, nas;
    } vec_t;

    typedef struct {
        logic [255:0] ex, ey, ez, ep;
        int           lat, nmul, nas, t0;
    } exp_t;

    vec_t         vt [6];
    exp_t         sb [$];
    exp_t         e;
    int           n_vec = 0, n_err = 0, n_done = 0;
    int           cyc = 0, t0 = 0, lat_k = 1, inj_cyc = -1;
    int           n_mul = 0, n_as = 0, mul_wait = 0, as_wait = 0;
    logic [255:0] cur_p = '0, mul_res = '0, as_res = '0;
    logic         prev_done = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mmul(logic [255:0] a, logic [255:0] b, logic [255:0] m);
        logic [511:0] t;
        t = ({256'b0, a} * {256'b0, b}) % {256'b0, m};
        return t[255:0];
    endfunction

    function automatic logic [255:0] maddsub(logic [255:0] a, logic [255:0] b, logic [255:0] m, logic sub);
        logic [256:0] s;
        if (sub) s = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, m} - {1'b0, b};
        else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
        end
        return s[255:0];
    endfunction

    // External units: ready/done arrives lat_k cycles after the start cycle.
    always @(negedge i_clk) begin
        i_mul_ready = (cyc == inj_cyc);
        i_as_done   = (cyc == inj_cyc);
        if (mul_wait > 0) begin
            mul_wait--;
            if (mul_wait == 0) begin i_mul_ready = 1'b1; i_mul_p = mul_res; end
        end
        if (as_wait > 0) begin
            as_wait--;
            if (as_wait == 0) begin i_as_done = 1'b1; i_as_result = as_res; end
        end
        if (o_mul_start) begin
            n_mul++;
            mul_wait = lat_k;
            mul_res  = mmul(o_mul_a, o_mul_b, cur_p);
        end
        if (o_as_start) begin
            n_as++;
            as_wait = lat_k;
            as_res  = maddsub(o_as_a, o_as_b, cur_p, o_as_sub);
        end
    end

    // Scoreboard monitor: every o_done pops one expectation.
    always @(negedge i_clk) begin
        if (prev_done) check("done_pulse", 256'(o_done), 256'd0);
        if (o_done) begin
            check("done_expected", 256'(sb.size() != 0), 256'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("X3", X3, e.ex);
                check("Y3", Y3, e.ey);
                check("Z3", Z3, e.ez);
                check("o_m", o_m, e.ep);
                check("latency", 256'(cyc - e.t0), 256'(e.lat));
                check("mul_starts", 256'(n_mul), 256'(e.nmul));
                check("as_starts", 256'(n_as), 256'(e.nas));
            end
            n_done++;
        end
        prev_done = o_done;
    end

    function automatic vec_t mkv(int pp, int x1, int y1, int z1, int x2, int y2, int z2, int k,
                                 int ex, int ey, int ez, int lat, int nm, int na);
        vec_t v;
        v.p = 256'(pp); v.x1 = 256'(x1); v.y1 = 256'(y1); v.z1 = 256'(z1);
        v.x2 = 256'(x2); v.y2 = 256'(y2); v.z2 = 256'(z2); v.k = k;
        v.ex = 256'(ex); v.ey = 256'(ey); v.ez = 256'(ez);
        v.lat = lat; v.nmul = nm; v.nas = na;
        return v;
    endfunction

    task automatic start_vec(input vec_t v, input bit push);
        exp_t x;
        @(negedge i_clk);
        lat_k = v.k; cur_p = v.p;
        p = v.p; X1 = v.x1; Y1 = v.y1; Z1 = v.z1; X2 = v.x2; Y2 = v.y2; Z2 = v.z2;
        n_mul = 0; n_as = 0;
        i_start = 1'b1;
        t0 = cyc;
        if (push) begin
            x.ex = v.ex; x.ey = v.ey; x.ez = v.ez; x.ep = v.p;
            x.lat = v.lat; x.nmul = v.nmul; x.nas = v.nas; x.t0 = t0;
            sb.push_back(x);
        end
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n0 = n_done;
        int i = 0;
        while (n_done == n0 && i < bound) begin
            @(negedge i_clk);
            i++;
        end
        check("done_seen", 256'(n_done != n0), 256'd1);
        @(negedge i_clk);
    endtask

    task automatic count_busy(input string name, input int ncyc);
        int b = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge i_clk);
            b += int'(o_busy);
        end
        check(name, 256'(b), 256'd0);
    endtask

    initial begin
        vt[0] = mkv(23, 3, 10, 1, 9, 7, 1, 1, 14, 19, 6, 47, 16, 7);
        vt[1] = mkv(23, 3, 10, 1, 9, 7, 1, 5, 14, 19, 6, 139, 16, 7);
        vt[2] = mkv(23, 9, 7, 1, 3, 10, 1, 2, 14, 4, 17, 70, 16, 7);
        vt[3] = mkv(23, 3, 10, 1, 3, 10, 1, 1, 0, 0, 0, 47, 16, 7);
`ifdef ECPA_INF_BYPASS_EN
        vt[4] = mkv(23, 3, 10, 0, 9, 7, 1, 1, 9, 7, 1, 1, 0, 0);
        vt[5] = mkv(23, 3, 10, 1, 9, 7, 0, 1, 3, 10, 1, 1, 0, 0);
`else
        vt[4] = mkv(23, 3, 10, 0, 9, 7, 1, 1, 4, 17, 0, 47, 16, 7);
        vt[5] = mkv(23, 3, 10, 1, 9, 7, 0, 1, 10, 22, 0, 47, 16, 7);
`endif

        repeat (3) @(negedge i_clk);
        check("rst_X3", X3, '0);
        check("rst_Y3", Y3, '0);
        check("rst_Z3", Z3, '0);
        check("rst_busy", 256'(o_busy), 256'd0);
        check("rst_done", 256'(o_done), 256'd0);
        check("rst_starts", 256'({o_mul_start, o_as_start, o_as_sub}), 256'd0);
        check("rst_o_m", o_m, '0);
        i_rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_vec(vt[i], 1'b1);
            wait_done(400);
        end

        // start re-pulsed while busy must be ignored
        start_vec(vt[0], 1'b1);
        while (cyc < t0 + 10) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(400);
        check("repulse_no_extra", 256'(sb.size()), 256'd0);

        // reset mid-run, then a stray ready two cycles later
        start_vec(vt[1], 1'b0);
        inj_cyc = t0 + 22;
        while (cyc < t0 + 20) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("abort_busy", 256'(o_busy), 256'd0);
        check("abort_X3", X3, '0);
        check("abort_Y3", Y3, '0);
        check("abort_Z3", Z3, '0);
        check("abort_starts", 256'({o_mul_start, o_as_start, o_as_sub}), 256'd0);
        check("abort_operands", o_mul_a | o_mul_b | o_as_a | o_as_b, '0);
        count_busy("abort_stays_idle", 40);
        inj_cyc = -1;
        start_vec(vt[0], 1'b1);
        wait_done(400);

        // reset and start in the same cycle: reset wins
        @(negedge i_clk);
        i_rst = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_start = 1'b0;
        count_busy("rst_start_dropped", 60);

        start_vec(vt[2], 1'b1);
        wait_done(400);
        check("sb_drained", 256'(sb.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_vec++;
        n_err++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ecpa_seq_ctrl.md
ECPA_SEQ_CTRL -- requirements
Module: ecpa_seq_ctrl

Interface
REQ-001 SHALL have ports i_clk (in, 1), the single clock, all logic on rising edge.
REQ-002 SHALL have port i_rst (in, 1), a synchronous active-high reset.
REQ-003 SHALL have ports i_start (in, 1) and p (in, 256); p is the modulus.
REQ-004 SHALL have ports X1, Y1, Z1, X2, Y2, Z2 (in, 256 each); these are the Jacobian points P and Q.
REQ-005 SHALL have ports X3, Y3, Z3 (out, 256 each) for the result R = P + Q, and o_busy and o_done (out, 1 each).
REQ-006 SHALL have ports o_mul_start (out, 1), o_mul_a and o_mul_b (out, 256 each), i_mul_p (in, 256) and i_mul_ready (in, 1); together these form the shared modular multiplier port.
REQ-007 SHALL have ports o_as_start (out, 1), o_as_sub (out, 1; 1=A-B, 0=A+B), o_as_a and o_as_b (out, 256 each), i_as_result (in, 256) and i_as_done (in, 1); together these form the shared modular add/sub port.
REQ-008 SHALL have port o_m (out, 256), which equals the latched p and drives the modulus of both units.

Function
REQ-009 SHALL sequence one point addition on a single external multiplier and a single external add/sub unit, one operation at a time.
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE; transitions are IDLE->ISSUE on i_start, ISSUE->WAIT, WAIT->ISSUE on the unit's ready when ops remain, WAIT->DONE on the last ready, and DONE->IDLE.
REQ-011 SHALL latch p and all six coordinates into the internal register file in the IDLE cycle that accepts i_start; i_start while o_busy=1 SHALL be ignored.
REQ-012 SHALL execute this fixed 23-op program, in this order, from a 5-bit program counter (0..22):
  - Z1Z2, Z1^2, Z2^2, Z1^3, Z2^3, U1=X1*Z2^2, U2=X2*Z1^2, S1=Y1*Z2^3, S2=Y2*Z1^3;
  - H=U2-U1, R=S2-S1, Z3=Z1Z2*H, H^2, H^3, V=U1*H^2, R^2, 2V=V+V;
  - T=R^2-H^3, X3=T-2V, W=V-X3, RW=R*W, SH=S1*H^3, Y3=RW-SH.
REQ-013 SHALL drive o_mul_start or o_as_start high for exactly one cycle, in ISSUE, with its operands valid in that cycle; operands SHALL be held stable until the ready.
REQ-014 SHALL, in WAIT, sample only the ready/done of the unit that was issued; ready in the ISSUE cycle SHALL be ignored. The result SHALL be written to its register on the ready cycle.
REQ-015 SHALL meet this latency: with ready returned k>=1 cycles after start, and i_start accepted at cycle T, o_done SHALL be high at T+1+23(k+1).
REQ-016 o_done SHALL be a one-cycle pulse. X3/Y3/Z3 SHALL update in the DONE cycle and hold until the next DONE or reset.
REQ-017 o_busy SHALL be 1 in ISSUE, WAIT and DONE, and 0 in IDLE.
REQ-018 SHALL not check operand ranges; inputs are assumed reduced mod p. H==0 (doubling or inverse case) SHALL run the full program without special handling.

Reset
REQ-019 i_rst=1 SHALL force, on the next edge: state IDLE, program counter 0, X3/Y3/Z3=0, o_done=0, o_busy=0, o_mul_start=0, o_as_start=0, o_as_sub=0, and all operand outputs 0.
REQ-020 SHALL abort any op in flight on reset; a late ready from an external unit after reset SHALL be ignored in IDLE.
REQ-021 i_rst and i_start in the same cycle SHALL resolve to reset, and the start SHALL be dropped.

Configuration
REQ-022 SHALL support macro ECPA_INF_BYPASS_EN. When defined, in the accept cycle, Z1==0 SHALL select output Q and otherwise Z2==0 SHALL select output P, going IDLE->DONE with no unit issued, so o_done is at T+1.
REQ-023 SHALL, without ECPA_INF_BYPASS_EN, have no zero-detect logic and always run the full 23-op program.

Structure
REQ-024 SHALL place the following in shared package ecpa_pkg: op_t enum (OP_MUL, OP_ADD, OP_SUB), reg_idx_t (4-bit register index), the uop_t struct {op, dst, srcA, srcB}, and ECPA_NUM_OPS=23.
REQ-025 SHALL implement the program as sub-module ecpa_ucode_rom (combinational: pc in, uop_t out); the FSM and register file stay in ecpa_seq_ctrl.

Verification
REQ-026 p=23, P=(3,10,1), Q=(9,7,1), k=1 -> X3=14, Y3=19, Z3=6 (affine (17,20)), with o_done at T+47.
REQ-027 Same operands with k=5 -> identical result, with o_done at T+139, exactly 16 o_mul_start pulses and 7 o_as_start pulses.
REQ-028 i_start re-pulsed at T+10 -> ignored; result and timing identical to REQ-026.
REQ-029 i_rst asserted at T+20, then a unit ready at T+22 -> IDLE with all outputs 0, no o_done; a fresh start then completes correctly.
REQ-030 ECPA_INF_BYPASS_EN defined, Z1=0, Q=(9,7,1) -> X3=9, Y3=7, Z3=1 at T+1 with no unit starts; without the macro -> full run, o_done at T+47.
REQ-031 P=Q=(3,10,1), k=1 -> H=0, Z3=0, o_done at T+47, no hang.
